// File: rtl/rgb_byte_packer.sv
// rgb_byte_packer
// Packs a raster-order R,G,B byte stream into 24-bit pixels tagged with
// their (x,y) position and start/end-of-line/frame markers.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   s_valid/s_ready/s_data  byte input stream (valid/ready)
//   m_valid/m_ready         pixel output stream (valid/ready)
//   m_pixel                 {R,G,B}
//   m_x, m_y                pixel position within the frame
//   m_sof, m_eol, m_eof     first pixel / last in line / last in frame
//   frame_done              one-cycle pulse after the eof pixel is taken
module rgb_byte_packer #(
    parameter int WIDTH  = 610,
    parameter int HEIGHT = 874,
    parameter int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    parameter int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [23:0]   m_pixel,
    output logic [XW-1:0] m_x,
    output logic [YW-1:0] m_y,
    output logic          m_sof,
    output logic          m_eol,
    output logic          m_eof,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    phase_t        phase, phase_nxt;
    logic [7:0]    r_q, g_q;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic          in_hs, out_hs, load;

    assign in_hs  = s_valid && s_ready;
    assign out_hs = m_valid && m_ready;
    assign load   = in_hs && (phase == PH_B);

    // Byte phase: state register
    always_ff @(posedge clk) begin
        if (rst) phase <= PH_R;
        else     phase <= phase_nxt;
    end

    // Byte phase: next state, advances only on accepted bytes
    always_comb begin
        phase_nxt = phase;
        if (in_hs) begin
            case (phase)
                PH_R:    phase_nxt = PH_G;
                PH_G:    phase_nxt = PH_B;
                default: phase_nxt = PH_R;
            endcase
        end
    end

    // Byte phase: outputs. Only the B byte needs a free output slot, so R
    // and G of the next pixel are taken even while the output is stalled.
    // Gated by rst so nothing is accepted in a reset cycle.
    always_comb begin
        s_ready = 1'b0;
        if (!rst) begin
            case (phase)
                PH_B:    s_ready = !m_valid || m_ready;
                default: s_ready = 1'b1;
            endcase
        end
    end

    // Partial pixel holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 8'd0;
            g_q <= 8'd0;
        end else if (in_hs) begin
            if (phase == PH_R) r_q <= s_data;
            if (phase == PH_G) g_q <= s_data;
        end
    end

    // Output register and raster position. A load in the same cycle as an
    // output handshake keeps m_valid high so the stream stays gapless.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_pixel    <= 24'd0;
            m_x        <= '0;
            m_y        <= '0;
            m_sof      <= 1'b0;
            m_eol      <= 1'b0;
            m_eof      <= 1'b0;
            next_x     <= '0;
            next_y     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_hs && m_eof;
            if (load) begin
                m_valid <= 1'b1;
                m_pixel <= {r_q, g_q, s_data};
                m_x     <= next_x;
                m_y     <= next_y;
                m_sof   <= (next_x == '0) && (next_y == '0);
                m_eol   <= (next_x == X_LAST);
                m_eof   <= (next_x == X_LAST) && (next_y == Y_LAST);
                if (next_x == X_LAST) begin
                    next_x <= '0;
                    next_y <= (next_y == Y_LAST) ? '0 : next_y + YW'(1);
                end else begin
                    next_x <= next_x + XW'(1);
                end
            end else if (out_hs) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rgb_byte_packer.md
# rgb_byte_packer

Streaming front-end of the image-inversion pipeline. Consumes the raw byte stream read from the input hex image (one byte per beat, R,G,B order, raster scan) and packs every three bytes into one 24-bit pixel with raster coordinates and frame markers. Its output feeds the pixel inversion stage over a valid/ready handshake. Holds at most one partial pixel and one complete output pixel.

## Interface

Parameters:
- WIDTH, 610, pixels per line (≥1)
- HEIGHT, 874, lines per frame (≥1)
- XW, max($clog2(WIDTH),1), derived; x coordinate width
- YW, max($clog2(HEIGHT),1), derived; y coordinate width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid && s_ready
- s_data  in  8  input byte
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts when m_valid && m_ready
- m_pixel  out  24  {R[23:16], G[15:8], B[7:0]}
- m_x  out  XW  pixel column, 0..WIDTH-1
- m_y  out  YW  pixel row, 0..HEIGHT-1
- m_sof  out  1  high with pixel (0,0)
- m_eol  out  1  high with pixel x==WIDTH-1
- m_eof  out  1  high with pixel (WIDTH-1,HEIGHT-1)
- frame_done  out  1  one-cycle pulse, cycle after the eof pixel handshakes

## Operation

- Byte phase counter: PH_R(0) → PH_G(1) → PH_B(2) → PH_R; advances only on input handshake.
- PH_R / PH_G: byte stored in R / G holding register; s_ready=1 unconditionally.
- PH_B: s_ready = !m_valid || m_ready. On handshake, {R,G,s_data} loads the output register with current position counters and derived flags; m_valid set.
- Output register: m_valid clears on output handshake unless a new pixel loads in the same cycle (load wins, m_valid stays 1).
- Position counters (next_x, next_y) advance on each output-register load: next_x wraps WIDTH-1 → 0 and increments next_y; next_y wraps HEIGHT-1 → 0 (next frame begins at (0,0), no idle required).
- Flags computed from position at load: m_sof = (x==0 && y==0); m_eol = (x==WIDTH-1); m_eof = m_eol && (y==HEIGHT-1). WIDTH=1: every pixel has m_eol. WIDTH=HEIGHT=1: every pixel has sof, eol and eof.
- frame_done: registered m_valid && m_ready && m_eof.
- Output fields (m_pixel, m_x, m_y, flags) stable while m_valid && !m_ready.
- No data transformation; byte values pass bit-exact.

## Timing

- Reset values: s_ready=0 during rst, 1 in first cycle after; m_valid=0, m_pixel=0, m_x=0, m_y=0, m_sof=0, m_eol=0, m_eof=0, frame_done=0; phase=PH_R; position=(0,0); partial R/G discarded.
- Reset mid-pixel or with m_valid=1: all state discarded; next accepted byte is R of pixel (0,0).
- Latency: m_valid rises the cycle after B byte handshake.
- Throughput: one pixel per 3 input beats; s_valid held high with m_ready=1 yields no stalls.
- Back-pressure: only B phase stalls; R and G of the next pixel are accepted while the output is stalled.
- s_valid gaps at any phase: phase and partial bytes held indefinitely.
- Simultaneous B handshake and output handshake: old pixel leaves, new pixel loads, m_valid continuous.

## Test plan

- Single pixel: bytes 0x12,0x34,0x56, m_ready=1 → m_pixel=0x123456, m_x=0, m_y=0, m_sof=1, m_eol=0, m_valid high exactly one cycle, one cycle after 0x56 accepted.
- Full frame, WIDTH=4, HEIGHT=2, bytes 0x00..0x17 → 8 pixels 0x000102..0x151617; m_eol on x=3 of both rows; m_eof only on pixel 7; frame_done pulses once; second frame restarts at (0,0) with m_sof=1.
- Back-pressure: m_ready=0 for 10 cycles while 6 bytes offered → R,G of pixel 1 accepted, s_ready=0 in PH_B, pixel 0 outputs stable; release m_ready → pixel 1 loads same cycle pixel 0 drains, no data lost.
- Random s_valid gaps and random m_ready (50%) over 3 frames at WIDTH=5, HEIGHT=3 → output equals scoreboard byte-packing of input, coordinates and flags correct, no duplicates.
- Reset after R,G accepted with m_valid=1 → m_valid=0 next cycle; next bytes 0xAA,0xBB,0xCC emerge as 0xAABBCC at (0,0) with m_sof=1.
- WIDTH=1, HEIGHT=1 → every pixel has m_sof=m_eol=m_eof=1 and frame_done pulses once per pixel.
